// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to packed-BCD converter with start/busy/done handshake
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t             state;
    logic [WIDTH-1:0]   sr;
    logic [SW-1:0]      sc;
    logic [SW-1:0]      corr;
    logic [CW-1:0]      cnt;
    logic [SW+WIDTH-1:0] sh;
    for (genvar i = 0; i < DIGITS; i++) begin : g_corr
        assign corr[4*i+:4] = (sc[4*i+:4] >= 4'd5) ? sc[4*i+:4] + 4'd3 : sc[4*i+:4];
    end
    assign sh = {corr, sr} << 1;
    // control FSM and datapath: load on accepted start, one corrected shift per cycle, publish on last
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
            sc    <= '0;
            sr    <= '0;
            cnt   <= '0;
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (start) begin
                sr    <= bin;
                sc    <= '0;
                cnt   <= CW'(WIDTH);
                busy  <= 1'b1;
                state <= SHIFT;
            end
        end else begin
            sc  <= sh[SW+WIDTH-1:WIDTH];
            sr  <= sh[WIDTH-1:0];
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                bcd   <= sh[SW+WIDTH-1:WIDTH];
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. Every iteration applies the per-digit "if ≥5 add 3" correction, then shifts the binary operand in one bit at a time. The block sits upstream of the BCD display/decoding path and feeds packed BCD digits to it. It uses a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 8, binary operand width in bits (≥1).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  WIDTH  binary operand; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd holds a new result.
- bcd  output  4*DIGITS  packed result; digit i occupies bits [4i+3:4i], digit 0 is the least significant.

## Operation
State machine: IDLE, SHIFT.

Internal registers:
- shift register sr of WIDTH bits, holding the operand.
- scratch sc of 4*DIGITS bits, holding the digits.
- iteration counter cnt, of width clog2(WIDTH+1).

IDLE:
- If start=1 at a rising edge: sr ← bin, sc ← 0, cnt ← WIDTH, busy ← 1, state ← SHIFT.
- Otherwise hold. done is forced to 0 every edge in IDLE, except the pulse defined below.

SHIFT, per edge:
1. Correct every digit of sc: each digit ≥5 gets +3 (4-bit result). Digits 0–4 pass unchanged.
2. Form {corrected_sc, sr} and shift left by 1. sc gets the upper 4*DIGITS bits and sr the lower WIDTH bits; the bit leaving the top of sc is discarded.
3. cnt ← cnt − 1.

Completion:
- When cnt=1 at the edge: bcd ← the shifted sc value computed in that same edge, done ← 1, busy ← 0, state ← IDLE.
- done is 1 for exactly one cycle.

General rules:
- bcd holds the last completed result until the next completion. It is not cleared by start.
- start while busy=1 is ignored and not queued. bin changes while busy have no effect.
- Valid operation never produces a digit 10–15 in sc. No special handling is required for such digits.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, bcd=0, sc=0, sr=0, cnt=0.
- Reset has priority over start and over an in-flight conversion. An aborted conversion produces no done pulse and leaves bcd=0.
- Acceptance: start sampled high in IDLE at edge k means busy=1 from k+1.
- Latency: iterations occur at edges k+1 … k+WIDTH. At edge k+WIDTH the new bcd, done=1 and busy=0 all appear together. For WIDTH=8 that is 8 cycles after the accepting edge.
- The cycle with done=1 is an IDLE cycle, so start=1 in it is accepted at the next edge.
- Throughput: with start held high, one accepted conversion every WIDTH+1 cycles.
- busy and done are never high in the same cycle.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, release with start=0 → busy=0, done=0, bcd=0x000 for 10+ cycles.
- Basic conversions (WIDTH=8, DIGITS=3): bin=0 → bcd=0x000; bin=99 → 0x099; bin=255 → 0x255; bin=128 → 0x128. Each must show done exactly 8 cycles after the accepting edge, high for 1 cycle, with busy high for the preceding 8 cycles.
- Correction-heavy values: bin=5 → 0x005, bin=59 → 0x059, bin=199 → 0x199. Also sweep all 0–255 against a reference model: every result must match and latency must be constant.
- Start during busy: start bin=200, then pulse start with bin=17 at cycles 3 and 7 → single result 0x200 at cycle 8, no second done. bcd stays 0x200 until a new start is accepted.
- Back-to-back: hold start=1 and change bin from 37 to 250 on the done cycle → results 0x037 then 0x250, with done pulses 9 cycles apart.
- Reset mid-conversion: start bin=255 and assert rst_n=0 after 4 iterations → busy=0, done never pulses, bcd=0. A following start with bin=42 yields 0x042 after 8 cycles.
